// File: rtl/regfile_writeback_unit.sv
// Regfile write-port master: merges ALU results and in-order load responses, tracks loads in flight.
// ALU write 1 cycle after accept, load write 2 cycles after response; hold slot drains every cycle, so responses never stall.
module regfile_writeback_unit #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alu_valid,
  input  logic [REG_AW-1:0]      alu_rd,
  input  logic [XLEN-1:0]        alu_result,
  output logic                   alu_ready,
  input  logic                   ld_issue_valid,
  input  logic [REG_AW-1:0]      ld_issue_rd,
  input  logic [2:0]             ld_issue_funct3,
  input  logic [1:0]             ld_issue_byteoff,
  output logic                   ld_issue_ready,
  input  logic                   mem_rsp_valid,
  input  logic [XLEN-1:0]        mem_rsp_data,
  output logic                   mem_rsp_ready,
  output logic                   writeEnable,
  output logic [REG_AW-1:0]      writeAddr,
  output logic [XLEN-1:0]        writeData,
  output logic [(1<<REG_AW)-1:0] busy_vec,
  output logic                   rsp_err
);
  localparam int PW   = $clog2(LQ_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << REG_AW;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic [1:0]        byteoff;
  } lq_entry_t;

  lq_entry_t         lq_q [LQ_DEPTH];
  lq_entry_t         lq_d [LQ_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              hold_vld_q, hold_vld_d;
  logic [REG_AW-1:0] hold_rd_q, hold_rd_d;
  logic [XLEN-1:0]   hold_dat_q, hold_dat_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              full, empty, push, pop, rsp_acc, hold_drain;
  lq_entry_t         head;
  logic [PW-1:0]     slot;
  logic [NREG-1:0]   busy;

  function automatic logic [XLEN-1:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
      3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
      3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  // Handshakes are held off while reset is asserted.
  always_comb begin
    full           = (count_q == CW'(LQ_DEPTH));
    empty          = (count_q == '0);
    head           = lq_q[rd_ptr_q];
    hold_drain     = hold_vld_q;
    ld_issue_ready = reset && !full;
    mem_rsp_ready  = reset && (!hold_vld_q || hold_drain);
    alu_ready      = reset && alu_valid && !hold_vld_q;
    push           = ld_issue_valid && ld_issue_ready;
    rsp_acc        = mem_rsp_valid && mem_rsp_ready;
    pop            = rsp_acc && !empty;

    lq_d = lq_q;
    if (push) lq_d[wr_ptr_q] = '{rd: ld_issue_rd, funct3: ld_issue_funct3, byteoff: ld_issue_byteoff};
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    hold_vld_d = hold_vld_q && !hold_drain;
    hold_rd_d  = hold_rd_q;
    hold_dat_d = hold_dat_q;
    if (pop) begin
      hold_vld_d = 1'b1;
      hold_rd_d  = head.rd;
      hold_dat_d = fmt_load(head.funct3, head.byteoff, mem_rsp_data);
    end
    err_d = err_q || (rsp_acc && empty);
  end

  // Hold slot wins the write port; address/data keep their last value when idle.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (hold_vld_q) begin
      we_d    = (hold_rd_q != '0);
      waddr_d = hold_rd_q;
      wdata_d = hold_dat_q;
    end else if (alu_ready) begin
      we_d    = (alu_rd != '0);
      waddr_d = alu_rd;
      wdata_d = alu_result;
    end
  end

  always_comb begin
    busy = '0;
    slot = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      slot = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) busy[lq_q[slot].rd] = 1'b1;
    end
    if (hold_vld_q) busy[hold_rd_q] = 1'b1;
    busy[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LQ_DEPTH; i++) lq_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      hold_vld_q <= 1'b0;
      hold_rd_q  <= '0;
      hold_dat_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      lq_q       <= lq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      hold_vld_q <= hold_vld_d;
      hold_rd_q  <= hold_rd_d;
      hold_dat_q <= hold_dat_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeData   = wdata_q;
  assign busy_vec    = busy;
  assign rsp_err     = err_q;
endmodule
